// File: rtl/issue_scoreboard.sv
// ============================================================================
// issue_scoreboard : in-order issue controller (RAW/WAW, write-port, MUL busy)
// Revision: 1.0
// ============================================================================
`default_nettype none

module issue_scoreboard #(
  parameter int LAT_ALU    = 1,
  parameter int LAT_MEM    = 3,
  parameter int LAT_MUL    = 4,
  parameter int RESV_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_wr_rd,
  input  logic [1:0]  id_fu,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        issue,
  output logic        iss_am_valid,
  output logic        iss_mem_valid,
  output logic        iss_mul_valid,
  output logic        stall,
  output logic [31:0] pending_mask
);

  localparam int c_LW = $clog2(RESV_DEPTH);
  localparam int c_CW = $clog2(LAT_MUL + 1);

  localparam logic [c_LW-1:0] c_LAT_ALU  = c_LW'(LAT_ALU);
  localparam logic [c_LW-1:0] c_LAT_MEM  = c_LW'(LAT_MEM);
  localparam logic [c_LW-1:0] c_LAT_MUL  = c_LW'(LAT_MUL);
  localparam logic [c_CW-1:0] c_MUL_LOAD = c_CW'(LAT_MUL - 1);

  localparam logic [1:0] c_FU_ALU = 2'd0;
  localparam logic [1:0] c_FU_MEM = 2'd1;
  localparam logic [1:0] c_FU_MUL = 2'd2;

  localparam logic [RESV_DEPTH-1:0] c_RESV_ONE = {{(RESV_DEPTH-1){1'b0}}, 1'b1};

  logic [31:0]            r_pending;
  logic [RESV_DEPTH-1:0]  r_resv;
  logic [c_CW-1:0]        r_mul_cnt;

  logic [c_LW-1:0]        w_lat;
  logic                   w_fu_legal;
  logic                   w_wr;
  logic                   w_raw1;
  logic                   w_raw2;
  logic                   w_waw;
  logic                   w_port;
  logic                   w_struct;
  logic                   w_issue;
  logic                   w_res_set;
  logic [RESV_DEPTH-1:0]  w_lat_oh;
  logic [RESV_DEPTH-1:0]  w_resv_next;
  logic [31:0]            w_set_vec;
  logic [31:0]            w_clr_vec;
  logic [31:0]            w_pend_next;
  logic [c_CW-1:0]        w_mul_next;

  always_comb begin
    w_lat      = c_LAT_ALU;
    w_fu_legal = 1'b1;
    case (id_fu)
      c_FU_ALU: w_lat = c_LAT_ALU;
      c_FU_MEM: w_lat = c_LAT_MEM;
      c_FU_MUL: w_lat = c_LAT_MUL;
      default:  w_fu_legal = 1'b0;
    endcase
  end

  // Hazards look only at registered state; a same-cycle write-back is not bypassed.
  assign w_wr     = id_wr_rd && (id_rd != 5'd0);
  assign w_raw1   = id_use_rs1 && (id_rs1 != 5'd0) && r_pending[id_rs1];
  assign w_raw2   = id_use_rs2 && (id_rs2 != 5'd0) && r_pending[id_rs2];
  assign w_waw    = w_wr && r_pending[id_rd];
  assign w_port   = w_wr && r_resv[w_lat];
  assign w_struct = (id_fu == c_FU_MUL) && (r_mul_cnt != '0);

  assign w_issue = id_valid && !flush && w_fu_legal &&
                   !(w_raw1 || w_raw2 || w_waw || w_port || w_struct);

  assign issue         = w_issue;
  assign iss_am_valid  = w_issue && (id_fu == c_FU_ALU);
  assign iss_mem_valid = w_issue && (id_fu == c_FU_MEM);
  assign iss_mul_valid = w_issue && (id_fu == c_FU_MUL);
  assign stall         = id_valid && !w_issue && !flush;
  assign pending_mask  = r_pending;

  // A write due L cycles out lands in slot L-1 after this edge's shift.
  assign w_res_set   = w_issue && w_wr;
  assign w_lat_oh    = c_RESV_ONE << w_lat;
  assign w_resv_next = (r_resv >> 1) | (w_res_set ? (w_lat_oh >> 1) : '0);

  assign w_set_vec = w_res_set ? (32'd1 << id_rd) : 32'd0;
  assign w_clr_vec = (wb_valid && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;

  always_comb begin
    w_pend_next    = (r_pending & ~w_clr_vec) | w_set_vec;
    w_pend_next[0] = 1'b0;
  end

  always_comb begin
    w_mul_next = r_mul_cnt;
    if (w_issue && (id_fu == c_FU_MUL)) begin
      w_mul_next = c_MUL_LOAD;
    end else if (r_mul_cnt != '0) begin
      w_mul_next = r_mul_cnt - c_CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= 32'd0;
      r_resv    <= '0;
      r_mul_cnt <= '0;
    end else begin
      r_pending <= w_pend_next;
      r_resv    <= w_resv_next;
      r_mul_cnt <= w_mul_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// ============================================================================
// tb_issue_scoreboard : directed self-checking bench for issue_scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_issue_scoreboard;

  logic        clock;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        id_wr_rd;
  logic [1:0]  id_fu;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        issue;
  logic        iss_am_valid;
  logic        iss_mem_valid;
  logic        iss_mul_valid;
  logic        stall;
  logic [31:0] pending_mask;

  int checks;
  int failures;

  issue_scoreboard dut (
    .clock         (clock),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .id_wr_rd      (id_wr_rd),
    .id_fu         (id_fu),
    .flush         (flush),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .issue         (issue),
    .iss_am_valid  (iss_am_valid),
    .iss_mem_valid (iss_mem_valid),
    .iss_mul_valid (iss_mul_valid),
    .stall         (stall),
    .pending_mask  (pending_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_instr(input logic v, input logic [1:0] fu, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic w);
    id_valid = v; id_fu = fu; id_rd = rd; id_wr_rd = w;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd);
    wb_valid = v; wb_rd = rd;
  endtask

  task automatic idle();
    set_instr(1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0);
    flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++; if (pending_mask !== 32'd0) begin failures++; $display("FAIL rst_pending got=%h exp=00000000", pending_mask); end
    checks++; if (issue !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rst_idle issue=%b stall=%b exp=0/0", issue, stall); end
    // c0/c1: two ALU writers fill x10 and x11
    set_instr(1'b1, 2'd0, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #2;
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL rst_fill0 issue got=%b exp=1", issue); end
    next_cycle();
    set_instr(1'b1, 2'd0, 5'd11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    next_cycle();
    idle();
    #2;
    checks++; if (pending_mask !== 32'h0000_0C00) begin failures++; $display("FAIL rst_prefill got=%h exp=00000c00", pending_mask); end
    reset = 1'b1;
    #1;
    checks++; if (pending_mask !== 32'd0) begin failures++; $display("FAIL rst_async_pending got=%h exp=00000000", pending_mask); end
    checks++; if (issue !== 1'b0) begin failures++; $display("FAIL rst_async_issue got=%b exp=0", issue); end
    next_cycle();
    reset = 1'b0;
    // Late write-back of x10 is ignored; x12 <- x10 is independent now
    set_instr(1'b1, 2'd0, 5'd12, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1);
    set_wb(1'b1, 5'd10);
    #2;
    checks++; if (issue !== 1'b1 || iss_am_valid !== 1'b1) begin failures++; $display("FAIL rst_after_issue issue=%b am=%b exp=1/1", issue, iss_am_valid); end
    next_cycle();
    idle();
    #2;
    checks++; if (pending_mask !== 32'h0000_1000) begin failures++; $display("FAIL rst_after_pending got=%h exp=00001000", pending_mask); end
  endtask

  task automatic test_raw_chain();
    do_reset();
    // c0 addi x10,x5,7
    set_instr(1'b1, 2'd0, 5'd10, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    #2;
    checks++; if (issue !== 1'b1 || iss_am_valid !== 1'b1 || iss_mem_valid !== 1'b0 || iss_mul_valid !== 1'b0) begin failures++; $display("FAIL raw_c0 issue=%b am=%b mem=%b mul=%b exp=1/1/0/0", issue, iss_am_valid, iss_mem_valid, iss_mul_valid); end
    next_cycle();
    // c1 addi x11,x10,8 with wb x10
    set_instr(1'b1, 2'd0, 5'd11, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1);
    set_wb(1'b1, 5'd10);
    #2;
    checks++; if (pending_mask !== 32'h0000_0400) begin failures++; $display("FAIL raw_c1_pending got=%h exp=00000400", pending_mask); end
    checks++; if (issue !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL raw_c1_stall issue=%b stall=%b exp=0/1", issue, stall); end
    next_cycle();
    set_wb(1'b0, 5'd0);
    #2;
    checks++; if (issue !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL raw_c2_issue issue=%b stall=%b exp=1/0", issue, stall); end
    next_cycle();
    // c3 add x12,x10,x11 with wb x11
    set_instr(1'b1, 2'd0, 5'd12, 5'd10, 1'b1, 5'd11, 1'b1, 1'b1);
    set_wb(1'b1, 5'd11);
    #2;
    checks++; if (issue !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL raw_c3_stall issue=%b stall=%b exp=0/1", issue, stall); end
    next_cycle();
    set_wb(1'b0, 5'd0);
    #2;
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL raw_c4_issue got=%b exp=1", issue); end
    next_cycle();
    idle();
    #2;
    checks++; if (pending_mask !== 32'h0000_1000) begin failures++; $display("FAIL raw_c5_pending got=%h exp=00001000", pending_mask); end
  endtask

  task automatic test_port_conflict();
    do_reset();
    set_instr(1'b1, 2'd1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #2;
    checks++; if (issue !== 1'b1 || iss_mem_valid !== 1'b1 || iss_am_valid !== 1'b0) begin failures++; $display("FAIL port_c0 issue=%b mem=%b am=%b exp=1/1/0", issue, iss_mem_valid, iss_am_valid); end
    next_cycle();
    idle();
    next_cycle();
    set_instr(1'b1, 2'd0, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #2;
    checks++; if (issue !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL port_c2_stall issue=%b stall=%b exp=0/1", issue, stall); end
    next_cycle();
    set_wb(1'b1, 5'd5);
    #2;
    checks++; if (issue !== 1'b1 || iss_am_valid !== 1'b1) begin failures++; $display("FAIL port_c3_issue issue=%b am=%b exp=1/1", issue, iss_am_valid); end
    next_cycle();
    idle();
    set_wb(1'b1, 5'd6);
    #2;
    checks++; if (pending_mask !== 32'h0000_0040) begin failures++; $display("FAIL port_c4_pending got=%h exp=00000040", pending_mask); end
    next_cycle();
    set_wb(1'b0, 5'd0);
    #2;
    checks++; if (pending_mask !== 32'd0) begin failures++; $display("FAIL port_c5_pending got=%h exp=00000000", pending_mask); end
  endtask

  task automatic test_mul_busy();
    do_reset();
    set_instr(1'b1, 2'd2, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #2;
    checks++; if (iss_mul_valid !== 1'b1 || issue !== 1'b1) begin failures++; $display("FAIL mul_c0 mul=%b issue=%b exp=1/1", iss_mul_valid, issue); end
    next_cycle();
    set_instr(1'b1, 2'd2, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      #2;
      checks++; if (stall !== 1'b1 || iss_mul_valid !== 1'b0) begin failures++; $display("FAIL mul_busy_c%0d stall=%b mul=%b exp=1/0", c, stall, iss_mul_valid); end
      next_cycle();
    end
    set_wb(1'b1, 5'd7);
    #2;
    checks++; if (iss_mul_valid !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL mul_c4 mul=%b stall=%b exp=1/0", iss_mul_valid, stall); end
    checks++; if (pending_mask !== 32'h0000_0080) begin failures++; $display("FAIL mul_c4_pending got=%h exp=00000080", pending_mask); end
    next_cycle();
    idle();
    #2;
    checks++; if (pending_mask !== 32'h0000_0100) begin failures++; $display("FAIL mul_c5_pending got=%h exp=00000100", pending_mask); end
  endtask

  task automatic test_x0();
    do_reset();
    // c0 addi x0,x0,1
    set_instr(1'b1, 2'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1);
    #2;
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL x0_c0_issue got=%b exp=1", issue); end
    next_cycle();
    // c1 consumer of x0
    set_instr(1'b1, 2'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    #2;
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL x0_c1_issue got=%b exp=1", issue); end
    checks++; if (pending_mask !== 32'd0) begin failures++; $display("FAIL x0_c1_pending got=%h exp=00000000", pending_mask); end
    next_cycle();
    // c2 MEM load into x0 must not reserve the c5 port slot
    set_instr(1'b1, 2'd1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #2;
    checks++; if (iss_mem_valid !== 1'b1) begin failures++; $display("FAIL x0_c2_mem got=%b exp=1", iss_mem_valid); end
    next_cycle();
    idle();
    next_cycle();
    set_instr(1'b1, 2'd0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #2;
    checks++; if (issue !== 1'b1 || pending_mask !== 32'd0) begin failures++; $display("FAIL x0_c4_resv issue=%b pending=%h exp=1/00000000", issue, pending_mask); end
    next_cycle();
    idle();
    #2;
    checks++; if (pending_mask !== 32'h0000_0010) begin failures++; $display("FAIL x0_c5_pending got=%h exp=00000010", pending_mask); end
  endtask

  task automatic test_flush_illegal();
    do_reset();
    set_instr(1'b1, 2'd0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    flush = 1'b1;
    #2;
    checks++; if (issue !== 1'b0 || stall !== 1'b0 || iss_am_valid !== 1'b0) begin failures++; $display("FAIL flush_c0 issue=%b stall=%b am=%b exp=0/0/0", issue, stall, iss_am_valid); end
    next_cycle();
    flush = 1'b0;
    #2;
    checks++; if (pending_mask !== 32'd0) begin failures++; $display("FAIL flush_c1_pending got=%h exp=00000000", pending_mask); end
    checks++; if (issue !== 1'b1 || iss_am_valid !== 1'b1) begin failures++; $display("FAIL flush_c1_issue issue=%b am=%b exp=1/1", issue, iss_am_valid); end
    next_cycle();
    // c2: WAW on x9 still pending
    #2;
    checks++; if (pending_mask !== 32'h0000_0200) begin failures++; $display("FAIL waw_c2_pending got=%h exp=00000200", pending_mask); end
    checks++; if (issue !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL waw_c2_stall issue=%b stall=%b exp=0/1", issue, stall); end
    // illegal FU never issues
    set_instr(1'b1, 2'd3, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #2;
    checks++; if (issue !== 1'b0 || stall !== 1'b1 || iss_am_valid !== 1'b0 || iss_mem_valid !== 1'b0 || iss_mul_valid !== 1'b0) begin failures++; $display("FAIL illegal_fu issue=%b stall=%b exp=0/1", issue, stall); end
    next_cycle();
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();
    next_cycle();
    test_reset();
    test_raw_chain();
    test_port_conflict();
    test_mul_busy();
    test_x0();
    test_flush_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
